// File: rtl/led_serial_pkg.sv
// Shared types and frame constants for the LED serial receive path.
package led_serial_pkg;

  localparam int LED_WORD_BITS = 32;

  localparam logic [LED_WORD_BITS-1:0] LED_START_FRAME = 32'h0000_0000;
  localparam logic [LED_WORD_BITS-1:0] LED_END_FRAME   = 32'hFFFF_FFFF;
  localparam logic [2:0]               LED_FRAME_HDR   = 3'b111;

  typedef logic [LED_WORD_BITS-1:0] led_word_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  function automatic logic is_start_frame(input led_word_t word);
    return word == LED_START_FRAME;
  endfunction

endpackage

// File: rtl/led_serial_rx_axis_sync.sv
// Lockstep synchronizer for the LED clock/data pair plus clock rising-edge detector.
module led_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic led_clk,
  input  logic led_data,
  output logic data_sync,
  output logic clk_rise
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sr   <= '0;
      data_sr  <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], led_clk};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], led_data};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  // Data is taken from the same stage as the clock so both see identical delay.
  assign data_sync = data_sr[SYNC_STAGES-1];
  assign clk_rise  = clk_sr[SYNC_STAGES-1] & ~clk_prev;

endmodule

// File: rtl/led_serial_rx_axis.sv
// LED serial (APA102-style) receiver: reassembles 32-bit MSB-first words onto AXI-Stream.
// Optional APA102 frame decode (start-frame drop, LED index on tuser): LED_RX_APA102_DECODE_EN.
module led_serial_rx_axis
  import led_serial_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int WORD_BITS    = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_led_clk,
  input  logic        i_led_data,
  output logic [31:0] m_axis_data,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tuser,
  output logic        o_overrun,
  output logic        o_sync_err
);

  localparam int CNT_W  = $clog2(WORD_BITS + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  logic              data_sync;
  logic              clk_rise;
  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  led_word_t         shift_reg_p0;
  logic              vld_p1;
  logic              emit;
  logic              pop;

  led_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (i_clk),
    .reset    (i_reset),
    .led_clk  (i_led_clk),
    .led_data (i_led_data),
    .data_sync(data_sync),
    .clk_rise (clk_rise)
  );

  // Stage p0: shift in bits, track word position and idle time.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= RX_IDLE;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      shift_reg_p0 <= '0;
      vld_p1       <= 1'b0;
      o_sync_err   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clk_rise) begin
        idle_cnt     <= '0;
        shift_reg_p0 <= {shift_reg_p0[LED_WORD_BITS-2:0], data_sync};
        case (state)
          RX_IDLE: begin
            bit_cnt <= CNT_W'(1);
            state   <= RX_SHIFT;
          end
          RX_SHIFT: begin
            if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= RX_IDLE;
              vld_p1  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: begin
            bit_cnt <= '0;
            state   <= RX_IDLE;
          end
        endcase
      end else if (idle_cnt != IDLE_W'(IDLE_TIMEOUT)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else if (state == RX_SHIFT) begin
        // Stalled mid-word: drop the partial word and resynchronise on the next edge.
        bit_cnt    <= '0;
        state      <= RX_IDLE;
        o_sync_err <= 1'b1;
      end
    end
  end

  assign pop = m_axis_tvalid & m_axis_tready;

`ifdef LED_RX_APA102_DECODE_EN
  logic [7:0] led_idx;

  assign emit = vld_p1 & ~is_start_frame(shift_reg_p0);

  // Stage p1: single-entry output register with frame-relative LED index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_data   <= '0;
      m_axis_tuser  <= '0;
      o_overrun     <= 1'b0;
      led_idx       <= '0;
    end else begin
      if (emit && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_data   <= shift_reg_p0;
        m_axis_tuser  <= led_idx;
        m_axis_tvalid <= 1'b1;
      end else begin
        if (pop) m_axis_tvalid <= 1'b0;
        if (emit) o_overrun <= 1'b1;
      end
      if (vld_p1) begin
        if (is_start_frame(shift_reg_p0)) begin
          led_idx <= '0;
        end else if (led_idx != 8'hFF) begin
          led_idx <= led_idx + 8'd1;
        end
      end
    end
  end
`else
  assign emit         = vld_p1;
  assign m_axis_tuser = '0;

  // Stage p1: single-entry output register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_data   <= '0;
      o_overrun     <= 1'b0;
    end else begin
      if (emit && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_data   <= shift_reg_p0;
        m_axis_tvalid <= 1'b1;
      end else begin
        if (pop) m_axis_tvalid <= 1'b0;
        if (emit) o_overrun <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_serial_rx_axis.sv
// Directed bench for led_serial_rx_axis: table of words plus multi-cycle corner-case sequences.
module tb_led_serial_rx_axis;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        led_clk;
  logic        led_data;
  logic        tready;
  logic [31:0] data;
  logic        tvalid;
  logic [7:0]  tuser;
  logic        overrun;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rx_q[$];
  logic [7:0]  ru_q[$];

  typedef struct {
    logic [31:0] word;
    logic        emit;
    logic [7:0]  user;
  } vec_t;

  vec_t vecs[6];

  led_serial_rx_axis #(
    .SYNC_STAGES (2),
    .IDLE_TIMEOUT(1024),
    .WORD_BITS   (32)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_led_clk    (led_clk),
    .i_led_data   (led_data),
    .m_axis_data  (data),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tuser (tuser),
    .o_overrun    (overrun),
    .o_sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Record every completed handshake.
  always @(posedge clk) begin
    if (tvalid && tready) begin
      rx_q.push_back(data);
      ru_q.push_back(tuser);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    led_clk  = 1'b0;
    led_data = 1'b0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_q.delete();
    ru_q.delete();
  endtask

  task automatic send_bit(input logic b);
    led_clk  = 1'b0;
    led_data = b;
    repeat (HALF) @(negedge clk);
    led_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // mode 0: plain; 1: latency check on final bit; 2: raise tready as the word completes
  task automatic send_word(input logic [31:0] w, input int mode, input logic [31:0] prev);
    for (int i = 31; i > 0; i--) send_bit(w[i]);
    led_clk  = 1'b0;
    led_data = w[0];
    repeat (HALF) @(negedge clk);
    led_clk = 1'b1;
    for (int c = 1; c <= HALF; c++) begin
      @(negedge clk);
      if (mode == 1 && c == 3) chk("lat_early", {31'd0, tvalid}, 32'd0);
      if (mode == 1 && c == 4) begin
        chk("lat_tvalid", {31'd0, tvalid}, 32'd1);
        chk("lat_data", data, w);
      end
      if (mode == 2 && c == 3) begin
        chk("simul_hold", {31'd0, tvalid}, 32'd1);
        chk("simul_old", data, prev);
        tready = 1'b1;
      end
      if (mode == 2 && c == 4) begin
        chk("simul_keep", {31'd0, tvalid}, 32'd1);
        chk("simul_new", data, w);
      end
    end
  endtask

  initial begin
`ifdef LED_RX_APA102_DECODE_EN
    vecs[0] = '{32'h0000_0000, 1'b0, 8'd0};
    vecs[1] = '{32'hE101_0203, 1'b1, 8'd0};
    vecs[2] = '{32'hE104_0506, 1'b1, 8'd1};
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 8'd2};
    vecs[4] = '{32'hDEAD_BEEF, 1'b1, 8'd3};
    vecs[5] = '{32'h0F0F_F0F0, 1'b1, 8'd4};
`else
    vecs[0] = '{32'h0000_0000, 1'b1, 8'd0};
    vecs[1] = '{32'hE101_0203, 1'b1, 8'd0};
    vecs[2] = '{32'hE104_0506, 1'b1, 8'd0};
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 8'd0};
    vecs[4] = '{32'hDEAD_BEEF, 1'b1, 8'd0};
    vecs[5] = '{32'h0F0F_F0F0, 1'b1, 8'd0};
`endif

    tready = 1'b1;
    do_reset();
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_tuser", {24'd0, tuser}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);

    // Single word with latency check.
    send_word(32'h8000_0001, 1, 32'd0);
    repeat (6) @(negedge clk);
    chk("single_count", rx_q.size(), 32'd1);
    chk("single_data", rx_q[0], 32'h8000_0001);
    chk("single_tvalid_low", {31'd0, tvalid}, 32'd0);

    // Table of words with tready held high.
    foreach (vecs[v]) begin
      rx_q.delete();
      ru_q.delete();
      send_word(vecs[v].word, 0, 32'd0);
      repeat (6) @(negedge clk);
      if (vecs[v].emit) begin
        chk($sformatf("vec%0d_count", v), rx_q.size(), 32'd1);
        chk($sformatf("vec%0d_data", v), rx_q[0], vecs[v].word);
        chk($sformatf("vec%0d_tuser", v), {24'd0, ru_q[0]}, {24'd0, vecs[v].user});
      end else begin
        chk($sformatf("vec%0d_dropped", v), rx_q.size(), 32'd0);
      end
    end

    // Back-pressure and overrun.
    do_reset();
    tready = 1'b0;
    send_word(32'hE0FF_0000, 0, 32'd0);
    repeat (6) @(negedge clk);
    chk("bp_first_valid", {31'd0, tvalid}, 32'd1);
    chk("bp_no_overrun", {31'd0, overrun}, 32'd0);
    send_word(32'hE100_00FF, 0, 32'd0);
    repeat (6) @(negedge clk);
    chk("bp_hold_data", data, 32'hE0FF_0000);
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    tready = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_count", rx_q.size(), 32'd1);
    chk("bp_accepted", rx_q[0], 32'hE0FF_0000);
    chk("bp_tvalid_low", {31'd0, tvalid}, 32'd0);
    chk("bp_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Simultaneous pop and push.
    do_reset();
    chk("simul_rst_overrun", {31'd0, overrun}, 32'd0);
    tready = 1'b0;
    send_word(32'h1111_2222, 0, 32'd0);
    repeat (6) @(negedge clk);
    send_word(32'h3333_4444, 2, 32'h1111_2222);
    repeat (6) @(negedge clk);
    chk("simul_count", rx_q.size(), 32'd2);
    chk("simul_first", rx_q[0], 32'h1111_2222);
    chk("simul_second", rx_q[1], 32'h3333_4444);
    chk("simul_overrun", {31'd0, overrun}, 32'd0);

    // Idle timeout resynchronisation.
    rx_q.delete();
    ru_q.delete();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    repeat (1100) @(negedge clk);
    chk("to_sync_err", {31'd0, sync_err}, 32'd1);
    chk("to_no_word", {31'd0, tvalid}, 32'd0);
    send_word(32'h1234_5678, 0, 32'd0);
    repeat (6) @(negedge clk);
    chk("to_count", rx_q.size(), 32'd1);
    chk("to_data", rx_q[0], 32'h1234_5678);

    // Reset mid-word with a held output word.
    tready = 1'b0;
    send_word(32'h5555_AAAA, 0, 32'd0);
    repeat (6) @(negedge clk);
    chk("mid_held", {31'd0, tvalid}, 32'd1);
    for (int i = 0; i < 17; i++) send_bit(~i[0]);
    do_reset();
    chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("mid_rst_data", data, 32'd0);
    chk("mid_rst_sync_err", {31'd0, sync_err}, 32'd0);
    tready = 1'b1;
    send_word(32'hA5A5_A5A5, 0, 32'd0);
    repeat (6) @(negedge clk);
    chk("mid_count", rx_q.size(), 32'd1);
    chk("mid_data", rx_q[0], 32'hA5A5_A5A5);
    chk("mid_overrun", {31'd0, overrun}, 32'd0);
    chk("mid_sync_err", {31'd0, sync_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
